add_share_sched: RTL and testbench

Round-robin scheduler that shares one signed WIDTH-bit adder and its output register among four requesters. Each requester either issues a plain add (a+b) or accumulates a into its own private accumulator (s = s + a). The block arbitrates, pipelines the shared adder over two stages, tags each result with the requester ID, and honours downstream backpressure. It sits between the per-channel front ends and the shared arithmetic unit in the datapath.

---
 rtl/add_share_sched_if.sv | 27 ++
 rtl/add_share_sched.sv | 115 +++++++++++
 tb/tb_add_share_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_share_sched_if.sv
// Request/result bundle between the four requester front ends and the shared adder scheduler.
// The master side drives requests and consumes results; the slave side is the scheduler.
interface add_share_sched_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [3:0]         mode;
    logic [4*WIDTH-1:0] a_bus;
    logic [4*WIDTH-1:0] b_bus;
    logic [3:0]         clr_acc;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   sum;
    logic [1:0]         sum_id;
    logic               sum_valid;
    logic               ovf;
    logic               out_ready;

    modport master (
        output req, mode, a_bus, b_bus, clr_acc, out_ready,
        input  ack, sum, sum_id, sum_valid, ovf
    );

    modport slave (
        input  req, mode, a_bus, b_bus, clr_acc, out_ready,
        output ack, sum, sum_id, sum_valid, ovf
    );
endinterface

// File: rtl/add_share_sched.sv
// Round-robin share of one signed adder among four requesters (add or private accumulate); 2-cycle latency.
// Backpressure: a held result stalls stage 2, stage 1 then holds and grants stop until out_ready returns.
module add_share_sched #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    add_share_sched_if.slave  bus
);
    logic [1:0]       ptr;
    logic             v1;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       id1;
    logic             mode1;
    logic [WIDTH-1:0] acc [4];

    logic [WIDTH-1:0] sum_r;
    logic [1:0]       sum_id_r;
    logic             sum_valid_r;
    logic             ovf_r;

    logic             stall2;
    logic             adv1;
    logic             grant;
    logic [1:0]       gnt_id;
    logic [1:0]       idx;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] add_res;
    logic             add_ovf;

    assign stall2 = sum_valid_r & ~bus.out_ready;
    assign adv1   = ~v1 | ~stall2;

    always_comb begin
        grant  = 1'b0;
        gnt_id = ptr;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!grant && bus.req[idx]) begin
                grant  = 1'b1;
                gnt_id = idx;
            end
        end
        if (reset || !adv1) begin
            grant = 1'b0;
        end
    end

    assign bus.ack = grant ? (4'b0001 << gnt_id) : 4'b0000;

    // Only stage 2 touches acc, so back-to-back accumulates on one ID see the fresh value.
    always_comb begin
        add_x   = mode1 ? acc[id1] : op_a;
        add_y   = mode1 ? op_a : op_b;
        add_res = add_x + add_y;
        add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_res[WIDTH-1] != add_x[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            v1          <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            id1         <= '0;
            mode1       <= 1'b0;
            sum_r       <= '0;
            sum_id_r    <= '0;
            sum_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (adv1) begin
                v1 <= grant;
                if (grant) begin
                    ptr   <= gnt_id + 2'd1;
                    op_a  <= bus.a_bus[int'(gnt_id)*WIDTH +: WIDTH];
                    op_b  <= bus.mode[gnt_id] ? '0 : bus.b_bus[int'(gnt_id)*WIDTH +: WIDTH];
                    id1   <= gnt_id;
                    mode1 <= bus.mode[gnt_id];
                end
            end

            if (!stall2) begin
                if (v1) begin
                    sum_r       <= add_res;
                    sum_id_r    <= id1;
                    sum_valid_r <= 1'b1;
                    ovf_r       <= add_ovf;
                end else begin
                    sum_valid_r <= 1'b0;
                end
            end

            // A clear beats a same-cycle accumulate write; the emitted sum keeps the computed value.
            for (int i = 0; i < 4; i++) begin
                if (bus.clr_acc[i]) begin
                    acc[i] <= '0;
                end else if (!stall2 && v1 && mode1 && (id1 == 2'(i))) begin
                    acc[i] <= add_res;
                end
            end
        end
    end

    assign bus.sum       = sum_r;
    assign bus.sum_id    = sum_id_r;
    assign bus.sum_valid = sum_valid_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_add_share_sched.sv
// Bench for add_share_sched: directed scenarios plus random traffic against a queue-based reference model.
module tb_add_share_sched;
    logic clk;
    logic reset;

    add_share_sched_if #(.WIDTH(8)) bus ();

    add_share_sched #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int s;
        int o;
        int t;
    } entry_t;

    entry_t sbq[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     mptr   = 0;
    int     macc[4];
    int     ra[4];
    int     rb[4];
    int     rm[4];

    logic [3:0] o_ack;
    logic       o_sv;
    logic [7:0] o_sum;
    logic [1:0] o_id;
    logic       o_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wrap8(input int v);
        int r;
        r = v & 255;
        if (r > 127) r = r - 256;
        return r;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic present(input int i, input int m, input int a, input int b);
        ra[i] = a;
        rb[i] = b;
        rm[i] = m;
        bus.req[i]          = 1'b1;
        bus.mode[i]         = m[0];
        bus.a_bus[i*8 +: 8] = a[7:0];
        bus.b_bus[i*8 +: 8] = b[7:0];
    endtask

    // One clock: check ack/sum against the model at negedge, update the model, drop acked requests.
    task automatic tick();
        int     exp_ack;
        int     j;
        int     g;
        int     full;
        entry_t e;
        @(negedge clk);
        o_ack = bus.ack;
        o_sv  = bus.sum_valid;
        o_sum = bus.sum;
        o_id  = bus.sum_id;
        o_ovf = bus.ovf;

        exp_ack = 0;
        g = -1;
        if (!(sbq.size() == 2 && !bus.out_ready)) begin
            for (int k = 0; k < 4; k++) begin
                j = (mptr + k) % 4;
                if (g < 0 && bus.req[j]) g = j;
            end
        end
        if (g >= 0) exp_ack = 1 << g;
        chk("ack", o_ack, exp_ack);
        chk("sum_valid", o_sv, (sbq.size() > 0) && (cyc - sbq[0].t >= 2));

        if (o_sv && bus.out_ready) begin
            chk("sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sum", o_sum, e.s & 255);
                chk("sum_id", o_id, e.id);
                chk("ovf", o_ovf, e.o);
            end
        end

        if (g >= 0) begin
            full = (rm[g] != 0) ? macc[g] + ra[g] : ra[g] + rb[g];
            e.id = g;
            e.s  = wrap8(full);
            e.o  = (full > 127 || full < -128) ? 1 : 0;
            e.t  = cyc;
            if (rm[g] != 0) macc[g] = e.s;
            sbq.push_back(e);
            mptr = (g + 1) % 4;
        end
        cyc++;

        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (o_ack[i]) bus.req[i] = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        bus.out_ready = 1'b1;
        g = 0;
        while (bus.req != 4'b0 && g < 40) begin
            tick();
            g++;
        end
        chk("drain_req_timeout", bus.req, 0);
        repeat (4) tick();
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic run_op(input int id, input int m, input int a, input int b,
                          input int exp_sum, input int exp_ovf);
        int g;
        present(id, m, a, b);
        g = 0;
        do begin
            tick();
            g++;
        end while (!o_ack[id] && g < 10);
        chk("op_ack_seen", o_ack[id], 1);
        g = 0;
        do begin
            tick();
            g++;
        end while (!(o_sv && o_id == 2'(id)) && g < 10);
        chk("op_result_seen", o_sv, 1);
        chk("op_sum", o_sum, exp_sum & 255);
        chk("op_ovf", o_ovf, exp_ovf);
    endtask

    initial begin
        logic [7:0] held;
        int         g;

        reset         = 1'b1;
        bus.req       = '0;
        bus.mode      = '0;
        bus.a_bus     = '0;
        bus.b_bus     = '0;
        bus.clr_acc   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            macc[i] = 0; ra[i] = 0; rb[i] = 0; rm[i] = 0;
        end
        #3;
        chk("rst_sum", bus.sum, 0);
        chk("rst_sum_id", bus.sum_id, 0);
        chk("rst_sum_valid", bus.sum_valid, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_ack", bus.ack, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin with all four requesting.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i]) present(i, 0, rnd8(), rnd8());
            end
            tick();
            chk("rr_ack", o_ack, 1 << (n % 4));
            if (n >= 2) chk("rr_latency_id", {o_sv, o_id}, {1'b1, 2'((n - 2) % 4)});
            else        chk("rr_empty_valid", o_sv, 0);
        end
        drain();

        // Plain adds with and without overflow.
        run_op(2, 0, 100, 50, -106, 1);
        run_op(2, 0, -3, 5, 2, 0);
        drain();

        // Back-to-back accumulates then a clear coinciding with the third write.
        for (int k = 0; k < 3; k++) begin
            present(1, 1, 10, rnd8());
            tick();
            chk("acc_ack", o_ack, 4'b0010);
        end
        chk("acc_sum10", {o_sv, o_sum}, {1'b1, 8'd10});
        bus.clr_acc = 4'b0010;
        macc[1] = 0;
        tick();
        chk("acc_sum20", {o_sv, o_sum}, {1'b1, 8'd20});
        bus.clr_acc = 4'b0000;
        tick();
        chk("acc_sum30", {o_sv, o_sum}, {1'b1, 8'd30});
        drain();
        run_op(1, 1, 1, 0, 1, 0);
        drain();

        // Backpressure with requesters 0 and 3.
        bus.out_ready = 1'b0;
        held = '0;
        for (int n = 0; n < 5; n++) begin
            if (!bus.req[0]) present(0, int'($urandom_range(0, 1)), rnd8(), rnd8());
            if (!bus.req[3]) present(3, int'($urandom_range(0, 1)), rnd8(), rnd8());
            tick();
            if (n == 2) held = o_sum;
            if (n >= 2) chk("bp_ack_zero", o_ack, 0);
            if (n >= 3) chk("bp_sum_hold", o_sum, held);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_grant", o_ack != 4'b0, 1);
        drain();

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (!bus.req[0]) present(0, 0, rnd8(), rnd8());
            tick();
        end
        chk("pre_reset_full", o_sv, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_sum_id", bus.sum_id, 0);
        chk("mid_rst_sum_valid", bus.sum_valid, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        chk("mid_rst_ack", bus.ack, 0);
        sbq.delete();
        mptr = 0;
        for (int i = 0; i < 4; i++) macc[i] = 0;
        bus.req = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("idle_valid", o_sv, 0);
            chk("idle_ack", o_ack, 0);
        end

        // Sparse: lone req[3] with ptr at 0, then scanning restarts at 0.
        present(3, 0, rnd8(), rnd8());
        tick();
        chk("sparse_ack3", o_ack, 4'b1000);
        for (int i = 0; i < 4; i++) present(i, 0, rnd8(), rnd8());
        tick();
        chk("sparse_next_ack0", o_ack, 4'b0001);
        drain();

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i] && $urandom_range(0, 1) == 1)
                    present(i, int'($urandom_range(0, 1)), rnd8(), rnd8());
            end
            tick();
        end
        g = 0;
        drain();
        g = sbq.size();
        chk("final_empty", g, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
